// File: rtl/iter_divider.sv
// iter_divider: unsigned radix-2 restoring divider, one quotient bit per cycle, valid/ready on both sides
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH-1:0]   s_dividend,
  input  logic [WIDTH-1:0]   s_divisor,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [2*WIDTH-1:0] m_data,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, q, dvs, rem_nx, q_nx;
  logic [WIDTH:0]   sh, t;
  logic             accept, last, div_zero;
  assign s_ready  = (state == IDLE) | (state == DONE & m_ready);
  assign m_valid  = state == DONE;
  assign busy     = state != IDLE;
  assign accept   = s_valid & s_ready & ~flush;
  assign last     = state == BUSY & cnt == CW'(1);
  assign div_zero = s_divisor == '0;
  // rem < d always holds, so the restored/subtracted value fits in WIDTH bits
  assign sh     = {rem, q[WIDTH-1]};
  assign t      = sh - {1'b0, dvs};
  assign rem_nx = t[WIDTH] ? sh[WIDTH-1:0] : t[WIDTH-1:0];
  assign q_nx   = {q[WIDTH-2:0], ~t[WIDTH]};
  always_comb begin
    state_nx = flush ? IDLE :
               accept ? (div_zero ? DONE : BUSY) :
               last ? DONE :
               (state == DONE & m_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      rem    <= '0;
      q      <= '0;
      dvs    <= '0;
      m_data <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      rem <= '0;
      q   <= s_dividend;
      dvs <= s_divisor;
      cnt <= div_zero ? '0 : CW'(WIDTH);
      if (div_zero) m_data <= {{WIDTH{1'b1}}, s_dividend};
    end else if (state == BUSY) begin
      rem <= rem_nx;
      q   <= q_nx;
      cnt <= cnt - CW'(1);
      if (last) m_data <= {q_nx, rem_nx};
    end
  end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed checks of latency, results, backpressure, flush and async reset
module tb_iter_divider;
  logic        clk = 0, rst_n = 0, flush = 0, s_valid = 0, m_ready = 0;
  logic [31:0] s_dividend = 0, s_divisor = 0;
  logic        s_ready, m_valid, busy;
  logic [63:0] m_data, held;
  int          checks = 0, errors = 0, n;
  bit          seen;

  iter_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
    .s_dividend(s_dividend), .s_divisor(s_divisor), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid();
    while (!m_valid && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] z, input logic [31:0] d,
                       input logic [63:0] exp, input int lat);
    s_dividend = z;
    s_divisor  = d;
    s_valid    = 1;
    m_ready    = 1;
    step();
    s_valid = 0;
    n = 1;
    wait_valid();
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_data"}, m_data, exp);
    step();
    chk({tag, "_pulse"}, 64'(m_valid), 64'd0);
  endtask

  initial begin
    #2;
    chk("rst_mvalid", 64'(m_valid), 64'd0);
    chk("rst_mdata", m_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    step();
    rst_n = 1;
    step();
    chk("idle_sready", 64'(s_ready), 64'd1);

    do_op("basic", 32'd100, 32'd7, {32'd14, 32'd2}, 33);
    do_op("divzero", 32'h1234, 32'd0, {32'hFFFFFFFF, 32'h00001234}, 1);
    do_op("max_by_1", 32'hFFFFFFFF, 32'd1, {32'hFFFFFFFF, 32'd0}, 33);
    do_op("small_by_max", 32'd5, 32'hFFFFFFFF, {32'd0, 32'd5}, 33);
    do_op("msb_by_3", 32'h80000000, 32'd3, {32'h2AAAAAAA, 32'd2}, 33);

    // backpressure then back-to-back accept on the transfer edge
    s_dividend = 32'd1000;
    s_divisor  = 32'd10;
    s_valid    = 1;
    m_ready    = 0;
    step();
    s_valid = 0;
    n = 1;
    wait_valid();
    chk("bp_lat", 64'(n), 64'd33);
    held = m_data;
    chk("bp_data", held, {32'd100, 32'd0});
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_data", m_data, {32'd100, 32'd0});
      chk("bp_hold_valid", 64'(m_valid), 64'd1);
      chk("bp_hold_sready", 64'(s_ready), 64'd0);
    end
    s_dividend = 32'd9;
    s_divisor  = 32'd2;
    s_valid    = 1;
    m_ready    = 1;
    #1;
    chk("b2b_sready", 64'(s_ready), 64'd1);
    step();
    s_valid = 0;
    chk("b2b_taken", 64'(m_valid), 64'd0);
    chk("b2b_busy", 64'(busy), 64'd1);
    n = 1;
    wait_valid();
    chk("b2b_lat", 64'(n), 64'd33);
    chk("b2b_data", m_data, {32'd4, 32'd1});
    step();
    chk("b2b_pulse", 64'(m_valid), 64'd0);

    // flush during iteration 10
    s_dividend = 32'd50;
    s_divisor  = 32'd5;
    s_valid    = 1;
    step();
    s_valid = 0;
    repeat (9) step();
    flush = 1;
    step();
    flush = 0;
    chk("flush_sready", 64'(s_ready), 64'd1);
    chk("flush_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      seen |= m_valid;
      step();
    end
    chk("flush_no_result", 64'(seen), 64'd0);
    do_op("after_flush", 32'd50, 32'd5, {32'd10, 32'd0}, 33);

    // asynchronous reset mid-operation
    s_dividend = 32'd100;
    s_divisor  = 32'd7;
    s_valid    = 1;
    step();
    s_valid = 0;
    repeat (5) step();
    #2;
    rst_n = 0;
    #1;
    chk("arst_mvalid", 64'(m_valid), 64'd0);
    chk("arst_mdata", m_data, 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    step();
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      seen |= m_valid;
    end
    chk("arst_no_stale", 64'(seen), 64'd0);
    chk("arst_sready", 64'(s_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
